tff_updown_counter: RTL and testbench

//  Synchronous modulo-N up/down counter built from per-bit tff cells.

---
 rtl/counter_pkg.sv | 15 +
 rtl/dff.sv | 18 +
 rtl/tff.sv | 21 ++
 rtl/tff_cnt_tgen.sv | 53 +++++
 rtl/tff_updown_counter.sv | 86 ++++++++
 tb/tb_tff_updown_counter.sv | 194 +++++++++++++++++++
 6 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter constants and width helper
// Direction encodings and a ceiling-log2 used for parameter legality checks.
package counter_pkg;

   localparam logic CNT_DIR_UP = 1'b1;
   localparam logic CNT_DIR_DN = 1'b0;

   function automatic int cnt_log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - single-bit D flop with asynchronous active-low reset
module dff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic q_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else         q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/tff.sv
// rtl/tff.sv - single-bit toggle flop with asynchronous active-low reset
module tff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic t_i,
   output logic q_o
);

   logic q_q;
   logic q_d;

   assign q_d = q_q ^ t_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else         q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/tff_cnt_tgen.sv
// rtl/tff_cnt_tgen.sv - toggle-vector generator for the modulo-N up/down counter
// Derives the next count, then T = q ^ next so the tff bank lands on it.
module tff_cnt_tgen
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] t_o,
   output logic             wrap_nxt_o,
   output logic             load_err_nxt_o
);

   // MODULUS may equal 2**WIDTH, so the range check needs one extra bit.
   localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] nxt;

   always_comb begin
      nxt            = count_i;
      wrap_nxt_o     = 1'b0;
      load_err_nxt_o = 1'b0;
      if (load_i) begin
         if ({1'b0, load_val_i} < MOD_W) nxt = load_val_i;
         else                            load_err_nxt_o = 1'b1;
      end else if (en_i) begin
         if (up_i == CNT_DIR_UP) begin
            if (count_i == TERM_UP) begin
               nxt        = '0;
               wrap_nxt_o = 1'b1;
            end else begin
               nxt = count_i + 1'b1;
            end
         end else begin
            if (count_i == '0) begin
               nxt        = TERM_UP;
               wrap_nxt_o = 1'b1;
            end else begin
               nxt = count_i - 1'b1;
            end
         end
      end
   end

   assign t_o = count_i ^ nxt;

endmodule

// File: rtl/tff_updown_counter.sv
// rtl/tff_updown_counter.sv - modulo-N up/down counter built from a tff bank
// Optional sticky overflow flag enabled by TFF_CNT_OVF_FLAG_EN.
module tff_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             load_err,
   output logic             ovf
);

   if (MODULUS < 2 || cnt_log2(MODULUS) > WIDTH) begin : g_bad_modulus
      $error("tff_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   logic [WIDTH-1:0] t_vec;
   logic             wrap_d;
   logic             load_err_d;

   tff_cnt_tgen #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_tgen (
      .count_i        (count),
      .en_i           (en),
      .up_i           (up),
      .load_i         (load),
      .load_val_i     (load_val),
      .t_o            (t_vec),
      .wrap_nxt_o     (wrap_d),
      .load_err_nxt_o (load_err_d)
   );

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      tff u_tff (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .t_i    (t_vec[i]),
         .q_o    (count[i])
      );
   end

   dff u_wrap_q (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (wrap_d),
      .q_o    (wrap)
   );

   dff u_load_err_q (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (load_err_d),
      .q_o    (load_err)
   );

`ifdef TFF_CNT_OVF_FLAG_EN
   logic ovf_d;

   // A wrap on the same edge as a clear keeps the flag set.
   assign ovf_d = wrap_d | (ovf & ~ovf_clr);

   dff u_ovf_q (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (ovf_d),
      .q_o    (ovf)
   );
`else
   logic unused_ovf_clr;

   assign unused_ovf_clr = ovf_clr;
   assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_tff_updown_counter.sv
// tb/tb_tff_updown_counter.sv - directed and model-checked bench for tff_updown_counter
module tb_tff_updown_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       ovf_clr = 1'b0;

   logic [3:0] a_count, b_count;
   logic       a_wrap, a_lerr, a_ovf;
   logic       b_wrap, b_lerr, b_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   int ma_c, ma_w, ma_e;
   int mb_c, mb_w, mb_e;

   always #5 clk = ~clk;

   tff_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .ovf_clr  (ovf_clr),
      .count    (a_count),
      .wrap     (a_wrap),
      .load_err (a_lerr),
      .ovf      (a_ovf)
   );

   tff_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .ovf_clr  (ovf_clr),
      .count    (b_count),
      .wrap     (b_wrap),
      .load_err (b_lerr),
      .ovf      (b_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int c, input int w, input int le);
      check({tag, "/a_count"}, 32'(a_count), c);
      check({tag, "/a_wrap"},  32'(a_wrap),  w);
      check({tag, "/a_lerr"},  32'(a_lerr),  le);
   endtask

   task automatic chk_b(input string tag, input int c, input int w, input int le);
      check({tag, "/b_count"}, 32'(b_count), c);
      check({tag, "/b_wrap"},  32'(b_wrap),  w);
      check({tag, "/b_lerr"},  32'(b_lerr),  le);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model(input int m, inout int c, output int w, output int e);
      w = 0;
      e = 0;
      if (load) begin
         if (int'(load_val) < m) c = int'(load_val);
         else                    e = 1;
      end else if (en) begin
         if (up) begin
            if (c == m - 1) begin c = 0; w = 1; end
            else c = c + 1;
         end else begin
            if (c == 0) begin c = m - 1; w = 1; end
            else c = c - 1;
         end
      end
   endtask

   initial begin
      // reset state, held while rst_n low
      #2;
      chk_a("rst", 0, 0, 0);
      check("rst/a_ovf", 32'(a_ovf), 0);
      check("rst/b_ovf", 32'(b_ovf), 0);
      step();
      step();
      chk_a("rst_hold", 0, 0, 0);
      rst_n = 1'b1;

      // count up through two full periods
      en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk_a($sformatf("up%0d", i), i % 10, (i % 10 == 0) ? 1 : 0, 0);
      end

      // count down from 0 with borrow wrap, then reverse
      up = 1'b0;
      step(); chk_a("dn9", 9, 1, 0);
      step(); chk_a("dn8", 8, 0, 0);
      step(); chk_a("dn7", 7, 0, 0);
      up = 1'b1;
      step(); chk_a("rev8", 8, 0, 0);

      // load priority over enable, and rejected loads
      load = 1'b1; load_val = 4'd7;
      step(); chk_a("ld7", 7, 0, 0);
      load_val = 4'd12;
      step(); chk_a("ld12", 7, 0, 1);
      load = 1'b0; en = 1'b0;
      step(); chk_a("hold7", 7, 0, 0);
      load = 1'b1; load_val = 4'd9;
      step(); chk_a("ld9", 9, 0, 0);
      load_val = 4'd10;
      step(); chk_a("ld10", 9, 0, 1);
      load = 1'b0;
      step(); chk_a("hold9", 9, 0, 0);

`ifdef TFF_CNT_OVF_FLAG_EN
      check("ovf_sticky", 32'(a_ovf), 1);
      ovf_clr = 1'b1;
      step(); check("ovf_clr", 32'(a_ovf), 0);
      en = 1'b1; up = 1'b1;
      step(); chk_a("ovf_wrap", 0, 1, 0);
      check("ovf_set_wins", 32'(a_ovf), 1);
      ovf_clr = 1'b0;
      step(); step(); step();
      chk_a("ovf_cnt3", 3, 0, 0);
      check("ovf_held", 32'(a_ovf), 1);
      ovf_clr = 1'b1; en = 1'b0;
      step(); check("ovf_clr3", 32'(a_ovf), 0);
      ovf_clr = 1'b0;
`else
      check("ovf_off", 32'(a_ovf), 0);
      check("ovf_off_b", 32'(b_ovf), 0);
`endif

      // asynchronous reset right after a wrap edge
      load = 1'b1; load_val = 4'd9; en = 1'b1; up = 1'b1;
      step();
      load = 1'b0;
      step(); chk_a("pre_rst", 0, 1, 0);
      #2 rst_n = 1'b0;
      #1 chk_a("mid_rst", 0, 0, 0);
      check("mid_rst/a_ovf", 32'(a_ovf), 0);
      step();
      rst_n = 1'b1;
      step(); chk_a("post_rst", 1, 0, 0);

      // power-of-two modulus roll-over both ways
      load = 1'b1; load_val = 4'd15; en = 1'b0;
      step(); chk_b("b_ld15", 15, 0, 0);
      load = 1'b0; en = 1'b1; up = 1'b1;
      step(); chk_b("b_roll_up", 0, 1, 0);
      up = 1'b0;
      step(); chk_b("b_roll_dn", 15, 1, 0);

      // random cycles against the reference model, both moduli
      load = 1'b1; load_val = 4'd0; en = 1'b0;
      step();
      ma_c = 0; mb_c = 0;
      for (int i = 0; i < 1000; i++) begin
         en       = 1'($urandom_range(0, 1));
         up       = 1'($urandom_range(0, 1));
         load     = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom_range(0, 15));
         model(10, ma_c, ma_w, ma_e);
         model(16, mb_c, mb_w, mb_e);
         step();
         chk_a($sformatf("rnd%0d", i), ma_c, ma_w, ma_e);
         chk_b($sformatf("rnd%0d", i), mb_c, mb_w, mb_e);
         check($sformatf("rnd%0d/excl", i), 32'(a_wrap & a_lerr), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
